// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM pipeline control slice: ALU commands,
// opcodes, condition codes, instruction modes, the control bundle and
// the SRAM wait FSM states.
package arm_ctrl_pkg;

  // ALU command encodings (4-bit, zero-extended to CMD_W at the top)
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_MOV = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_ADC = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SBC = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_ORR = 4'd7;
  localparam logic [3:0] ALU_EOR = 4'd8;
  localparam logic [3:0] ALU_MVN = 4'd9;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ARM condition field codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_LS  = 2'b01,
    MODE_BR  = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       s;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       valid;
  } ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // ARM condition check against {N,Z,C,V}; 1111 never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/arm_ctrl_decode.sv
// Combinational instruction decode: turns opcode/mode/S into a control
// bundle, flags illegal encodings and squashes anything that is not a
// live, legal, condition-passing instruction into a bubble.
module arm_ctrl_decode
  import arm_ctrl_pkg::*;
#(
  parameter int USE_COND = 1
) (
  input  logic       id_valid,
  input  logic [3:0] opcode,
  input  logic [1:0] mode,
  input  logic       s_in,
  input  logic [3:0] cond,
  input  logic [3:0] status_nzcv,
  output ctrl_t      ctrl,
  output logic       illegal
);

  ctrl_t raw;
  logic  known;
  logic  pass;

  // Raw decode of mode and opcode, before validity/condition gating
  always_comb begin
    raw   = '0;
    known = 1'b0;
    case (mode_e'(mode))
      MODE_DP: begin
        known     = 1'b1;
        raw.s     = s_in;
        raw.wb_en = 1'b1;
        case (opcode)
          OP_MOV: raw.alu_cmd = ALU_MOV;
          OP_MVN: raw.alu_cmd = ALU_MVN;
          OP_ADD: raw.alu_cmd = ALU_ADD;
          OP_ADC: raw.alu_cmd = ALU_ADC;
          OP_SUB: raw.alu_cmd = ALU_SUB;
          OP_SBC: raw.alu_cmd = ALU_SBC;
          OP_AND: raw.alu_cmd = ALU_AND;
          OP_ORR: raw.alu_cmd = ALU_ORR;
          OP_EOR: raw.alu_cmd = ALU_EOR;
          OP_CMP: begin
            raw.alu_cmd = ALU_SUB;
            raw.s       = 1'b1;
            raw.wb_en   = 1'b0;
          end
          OP_TST: begin
            raw.alu_cmd = ALU_AND;
            raw.s       = 1'b1;
            raw.wb_en   = 1'b0;
          end
          default: known = 1'b0;
        endcase
      end
      MODE_LS: begin
        known         = 1'b1;
        raw.alu_cmd   = ALU_ADD;
        raw.mem_read  = s_in;
        raw.mem_write = !s_in;
        raw.wb_en     = s_in;
      end
      MODE_BR: begin
        known      = 1'b1;
        raw.branch = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Gate the raw bundle: only live, legal, condition-passing instructions survive
  always_comb begin
    pass    = (USE_COND != 0) ? cond_pass(cond, status_nzcv) : 1'b1;
    illegal = id_valid && !known;
    ctrl    = '0;
    if (id_valid && known && pass) begin
      ctrl       = raw;
      ctrl.valid = 1'b1;
    end
  end

endmodule

// File: rtl/arm_ctrl_pipe.sv
// Pipeline control unit: registers the decoded control bundle into ID/EX
// and EX/MEM, runs the SRAM wait FSM that freezes the pipe during memory
// accesses, and squashes the wrong-path instruction after a taken branch.
module arm_ctrl_pipe
  import arm_ctrl_pkg::*;
#(
  parameter int CMD_W            = 4,
  parameter int SRAM_WAIT_CYCLES = 4,
  parameter int USE_COND         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       opcode,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic [3:0]       cond,
  input  logic [3:0]       status_nzcv,
  input  logic             hazard_stall,
  output logic [CMD_W-1:0] ex_alu_cmd,
  output logic             ex_s,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_wb_en,
  output logic             ex_branch,
  output logic             ex_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_wb_en,
  output logic             branch_taken,
  output logic             freeze,
  output logic             mem_done,
  output logic             illegal
);

  localparam int CNT_W = (SRAM_WAIT_CYCLES > 1) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SRAM_WAIT_CYCLES - 1);

  ctrl_t            dec_ctrl;
  ctrl_t            idex_d, idex_q;
  logic             mem_read_d, mem_read_q;
  logic             mem_write_d, mem_write_q;
  logic             mem_wb_en_d, mem_wb_en_q;
  mem_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             take_branch;

  arm_ctrl_decode #(
    .USE_COND(USE_COND)
  ) u_decode (
    .id_valid   (id_valid),
    .opcode     (opcode),
    .mode       (mode),
    .s_in       (s_in),
    .cond       (cond),
    .status_nzcv(status_nzcv),
    .ctrl       (dec_ctrl),
    .illegal    (illegal)
  );

  assign take_branch = idex_q.valid && idex_q.branch;

  // SRAM wait FSM: freeze from the first MEM cycle until the counter drains
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freeze   = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_q || mem_write_q) begin
          freeze  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          mem_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-state for ID/EX and EX/MEM: freeze holds, branch and stall insert bubbles
  always_comb begin
    idex_d      = idex_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_wb_en_d = mem_wb_en_q;
    if (!freeze) begin
      if (take_branch || hazard_stall) begin
        idex_d = '0;
      end else begin
        idex_d = dec_ctrl;
      end
      mem_read_d  = idex_q.valid && idex_q.mem_read;
      mem_write_d = idex_q.valid && idex_q.mem_write;
      mem_wb_en_d = idex_q.valid && idex_q.wb_en;
    end
  end

  // Pipeline registers and FSM state; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wb_en_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      idex_q      <= idex_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wb_en_q <= mem_wb_en_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_alu_cmd   = CMD_W'(idex_q.alu_cmd);
  assign ex_s         = idex_q.s;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_wb_en     = idex_q.wb_en;
  assign ex_branch    = idex_q.branch;
  assign ex_valid     = idex_q.valid;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_wb_en    = mem_wb_en_q;
  assign branch_taken = take_branch;

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// Directed bench for arm_ctrl_pipe: one instance with a 4-cycle SRAM wait
// and a 4-bit command, a second with a 1-cycle wait and a 6-bit command,
// both driven from the same stimulus.
module tb_arm_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] opcode;
  logic [1:0] mode;
  logic       s_in;
  logic [3:0] cond;
  logic [3:0] status_nzcv;
  logic       hazard_stall;

  logic [3:0] ex_alu_cmd;
  logic       ex_s, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_valid;
  logic       mem_read, mem_write, mem_wb_en;
  logic       branch_taken, freeze, mem_done, illegal;

  logic [5:0] w1_ex_alu_cmd;
  logic       w1_ex_s, w1_ex_mem_read, w1_ex_mem_write, w1_ex_wb_en, w1_ex_branch, w1_ex_valid;
  logic       w1_mem_read, w1_mem_write, w1_mem_wb_en;
  logic       w1_branch_taken, w1_freeze, w1_mem_done, w1_illegal;

  int checks = 0;
  int errors = 0;

  arm_ctrl_pipe #(
    .CMD_W(4), .SRAM_WAIT_CYCLES(4), .USE_COND(1)
  ) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .mode(mode),
    .s_in(s_in), .cond(cond), .status_nzcv(status_nzcv), .hazard_stall(hazard_stall),
    .ex_alu_cmd(ex_alu_cmd), .ex_s(ex_s), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .ex_branch(ex_branch),
    .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .freeze(freeze),
    .mem_done(mem_done), .illegal(illegal)
  );

  arm_ctrl_pipe #(
    .CMD_W(6), .SRAM_WAIT_CYCLES(1), .USE_COND(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .mode(mode),
    .s_in(s_in), .cond(cond), .status_nzcv(status_nzcv), .hazard_stall(hazard_stall),
    .ex_alu_cmd(w1_ex_alu_cmd), .ex_s(w1_ex_s), .ex_mem_read(w1_ex_mem_read),
    .ex_mem_write(w1_ex_mem_write), .ex_wb_en(w1_ex_wb_en), .ex_branch(w1_ex_branch),
    .ex_valid(w1_ex_valid), .mem_read(w1_mem_read), .mem_write(w1_mem_write),
    .mem_wb_en(w1_mem_wb_en), .branch_taken(w1_branch_taken), .freeze(w1_freeze),
    .mem_done(w1_mem_done), .illegal(w1_illegal)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] md,
                               input logic s, input logic [3:0] cnd, input logic [3:0] nzcv,
                               input logic hz);
    id_valid     = v;
    opcode       = op;
    mode         = md;
    s_in         = s;
    cond         = cnd;
    status_nzcv  = nzcv;
    hazard_stall = hz;
    #1;
  endtask

  task automatic bubbleIn();
    applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    bubbleIn();
    step();
    step();
    checkOutput("rst_ex_valid", {7'd0, ex_valid}, 8'd0);
    checkOutput("rst_ex_alu_cmd", {4'd0, ex_alu_cmd}, 8'd0);
    checkOutput("rst_mem_read", {7'd0, mem_read}, 8'd0);
    checkOutput("rst_freeze", {7'd0, freeze}, 8'd0);
    rst = 1'b0;

    // ADD S=1 AL
    applyStimulus(1'b1, 4'b0100, 2'b00, 1'b1, 4'b1110, 4'b0000, 1'b0);
    checkOutput("add_illegal", {7'd0, illegal}, 8'd0);
    step();
    checkOutput("add_alu", {4'd0, ex_alu_cmd}, 8'd2);
    checkOutput("add_s", {7'd0, ex_s}, 8'd1);
    checkOutput("add_wb", {7'd0, ex_wb_en}, 8'd1);
    checkOutput("add_valid", {7'd0, ex_valid}, 8'd1);
    checkOutput("w1_add_alu", {2'd0, w1_ex_alu_cmd}, 8'd2);

    // CMP EQ with Z set passes; S forced, no writeback
    applyStimulus(1'b1, 4'b1010, 2'b00, 1'b0, 4'b0000, 4'b0100, 1'b0);
    step();
    checkOutput("cmp_alu", {4'd0, ex_alu_cmd}, 8'd4);
    checkOutput("cmp_s", {7'd0, ex_s}, 8'd1);
    checkOutput("cmp_wb", {7'd0, ex_wb_en}, 8'd0);
    checkOutput("cmp_valid", {7'd0, ex_valid}, 8'd1);
    checkOutput("add_mem_wb", {7'd0, mem_wb_en}, 8'd1);

    // Same CMP with Z clear fails the condition
    applyStimulus(1'b1, 4'b1010, 2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step();
    checkOutput("cmp_fail_valid", {7'd0, ex_valid}, 8'd0);
    checkOutput("cmp_fail_alu", {4'd0, ex_alu_cmd}, 8'd0);

    // SUB GT with N=V=1, Z=0 passes; LT with the same flags fails
    applyStimulus(1'b1, 4'b0010, 2'b00, 1'b0, 4'b1100, 4'b1001, 1'b0);
    step();
    checkOutput("sub_gt_valid", {7'd0, ex_valid}, 8'd1);
    checkOutput("sub_gt_alu", {4'd0, ex_alu_cmd}, 8'd4);
    applyStimulus(1'b1, 4'b0010, 2'b00, 1'b0, 4'b1011, 4'b1001, 1'b0);
    step();
    checkOutput("sub_lt_valid", {7'd0, ex_valid}, 8'd0);

    // MVN HI with C=1, Z=0 passes
    applyStimulus(1'b1, 4'b1111, 2'b00, 1'b0, 4'b1000, 4'b0010, 1'b0);
    step();
    checkOutput("mvn_alu", {4'd0, ex_alu_cmd}, 8'd9);
    checkOutput("mvn_s", {7'd0, ex_s}, 8'd0);

    // Illegal encodings and the never condition
    applyStimulus(1'b1, 4'b0100, 2'b11, 1'b0, 4'b1110, 4'b0000, 1'b0);
    checkOutput("mode11_illegal", {7'd0, illegal}, 8'd1);
    step();
    checkOutput("mode11_valid", {7'd0, ex_valid}, 8'd0);
    applyStimulus(1'b1, 4'b0011, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0);
    checkOutput("op0011_illegal", {7'd0, illegal}, 8'd1);
    step();
    checkOutput("op0011_valid", {7'd0, ex_valid}, 8'd0);
    applyStimulus(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1111, 4'b0000, 1'b0);
    checkOutput("nv_illegal", {7'd0, illegal}, 8'd0);
    step();
    checkOutput("nv_valid", {7'd0, ex_valid}, 8'd0);
    bubbleIn();
    checkOutput("idle_illegal", {7'd0, illegal}, 8'd0);
    step();

    // LDR followed by ADD: freeze 4 cycles, mem_done on the 5th
    applyStimulus(1'b1, 4'b0000, 2'b01, 1'b1, 4'b1110, 4'b0000, 1'b0);
    step();
    checkOutput("ldr_ex_read", {7'd0, ex_mem_read}, 8'd1);
    checkOutput("ldr_ex_wb", {7'd0, ex_wb_en}, 8'd1);
    checkOutput("ldr_ex_alu", {4'd0, ex_alu_cmd}, 8'd2);
    checkOutput("ldr_ex_s", {7'd0, ex_s}, 8'd0);
    applyStimulus(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0);
    step();
    bubbleIn();
    checkOutput("ldr_mem_read", {7'd0, mem_read}, 8'd1);
    checkOutput("ldr_mem_wb", {7'd0, mem_wb_en}, 8'd1);
    checkOutput("w1_ldr_freeze_c1", {7'd0, w1_freeze}, 8'd1);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("ldr_freeze_c%0d", c), {7'd0, freeze}, 8'd1);
      checkOutput($sformatf("ldr_done_c%0d", c), {7'd0, mem_done}, 8'd0);
      checkOutput($sformatf("ldr_hold_ex_c%0d", c), {4'd0, ex_alu_cmd}, 8'd2);
      checkOutput($sformatf("ldr_hold_mem_c%0d", c), {7'd0, mem_read}, 8'd1);
      step();
      if (c == 1) begin
        checkOutput("w1_ldr_freeze_c2", {7'd0, w1_freeze}, 8'd0);
        checkOutput("w1_ldr_done_c2", {7'd0, w1_mem_done}, 8'd1);
      end
    end
    checkOutput("ldr_freeze_c5", {7'd0, freeze}, 8'd0);
    checkOutput("ldr_done_c5", {7'd0, mem_done}, 8'd1);
    checkOutput("ldr_ex_add_held", {7'd0, ex_valid}, 8'd1);
    step();
    checkOutput("adv_mem_read", {7'd0, mem_read}, 8'd0);
    checkOutput("adv_mem_wb", {7'd0, mem_wb_en}, 8'd1);
    checkOutput("adv_ex_valid", {7'd0, ex_valid}, 8'd0);
    checkOutput("adv_freeze", {7'd0, freeze}, 8'd0);

    // Branch in ID/EX with ADD in ID: ADD is squashed
    applyStimulus(1'b1, 4'b0000, 2'b10, 1'b0, 4'b1110, 4'b0000, 1'b0);
    step();
    checkOutput("br_ex_branch", {7'd0, ex_branch}, 8'd1);
    checkOutput("br_ex_wb", {7'd0, ex_wb_en}, 8'd0);
    applyStimulus(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0);
    checkOutput("br_taken", {7'd0, branch_taken}, 8'd1);
    step();
    checkOutput("br_flush_valid", {7'd0, ex_valid}, 8'd0);
    checkOutput("br_flush_alu", {4'd0, ex_alu_cmd}, 8'd0);
    checkOutput("br_mem_wb", {7'd0, mem_wb_en}, 8'd0);
    bubbleIn();
    step();

    // Branch in ID/EX while an LDR freezes MEM: flush waits for freeze to drop
    applyStimulus(1'b1, 4'b0000, 2'b01, 1'b1, 4'b1110, 4'b0000, 1'b0);
    step();
    applyStimulus(1'b1, 4'b0000, 2'b10, 1'b0, 4'b1110, 4'b0000, 1'b0);
    step();
    applyStimulus(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0);
    checkOutput("frz_br_freeze", {7'd0, freeze}, 8'd1);
    checkOutput("frz_br_taken", {7'd0, branch_taken}, 8'd1);
    step();
    checkOutput("frz_br_hold_c2", {7'd0, ex_branch}, 8'd1);
    checkOutput("frz_br_valid_c2", {7'd0, ex_valid}, 8'd1);
    step();
    step();
    checkOutput("frz_br_hold_c4", {7'd0, ex_branch}, 8'd1);
    step();
    checkOutput("frz_br_freeze_c5", {7'd0, freeze}, 8'd0);
    checkOutput("frz_br_done_c5", {7'd0, mem_done}, 8'd1);
    checkOutput("frz_br_hold_c5", {7'd0, ex_valid}, 8'd1);
    step();
    checkOutput("frz_br_flush", {7'd0, ex_valid}, 8'd0);
    checkOutput("frz_br_mem_read", {7'd0, mem_read}, 8'd0);
    bubbleIn();
    step();

    // Hazard stall bubbles a STR; the STR then reaches MEM without writeback
    applyStimulus(1'b1, 4'b0000, 2'b01, 1'b0, 4'b1110, 4'b0000, 1'b1);
    step();
    checkOutput("stall_valid", {7'd0, ex_valid}, 8'd0);
    applyStimulus(1'b1, 4'b0000, 2'b01, 1'b0, 4'b1110, 4'b0000, 1'b0);
    step();
    checkOutput("str_ex_write", {7'd0, ex_mem_write}, 8'd1);
    checkOutput("str_ex_wb", {7'd0, ex_wb_en}, 8'd0);
    checkOutput("str_ex_valid", {7'd0, ex_valid}, 8'd1);
    bubbleIn();
    step();
    checkOutput("str_mem_write", {7'd0, mem_write}, 8'd1);
    checkOutput("str_mem_wb", {7'd0, mem_wb_en}, 8'd0);
    checkOutput("str_freeze", {7'd0, freeze}, 8'd1);
    step();
    step();
    step();
    step();
    checkOutput("str_done", {7'd0, mem_done}, 8'd1);
    step();
    checkOutput("str_cleared", {7'd0, mem_write}, 8'd0);

    // Reset in the second WAIT cycle abandons the access immediately
    applyStimulus(1'b1, 4'b0000, 2'b01, 1'b1, 4'b1110, 4'b0000, 1'b0);
    step();
    bubbleIn();
    step();
    step();
    step();
    checkOutput("pre_rst_freeze", {7'd0, freeze}, 8'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_mem_read", {7'd0, mem_read}, 8'd0);
    checkOutput("midrst_mem_wb", {7'd0, mem_wb_en}, 8'd0);
    checkOutput("midrst_freeze", {7'd0, freeze}, 8'd0);
    checkOutput("midrst_done", {7'd0, mem_done}, 8'd0);
    step();
    rst = 1'b0;
    step();
    checkOutput("postrst_freeze", {7'd0, freeze}, 8'd0);
    checkOutput("postrst_valid", {7'd0, ex_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
